mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port synchronous program/data RAM between two requesters:
  - CPU port (c_), driven by the core's MA/MD transfer sequencing.
  - Loader/debug port (l_), used for program download and memory inspection.
- Round-robin arbitration, one memory access in flight at a time, and a loader lock that holds off the CPU during download.
- Sits between the core datapath/control path and the RAM macro.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_c_req  in  1  CPU access request; held until o_c_gnt.
- i_c_we  in  1  CPU write enable (1=write, 0=read).
- i_c_addr  in  ADDR_W  CPU address.
- i_c_wdata  in  DATA_W  CPU write data.
- o_c_gnt  out  1  one-cycle pulse: CPU access issued to RAM.
- o_c_rvalid  out  1  one-cycle pulse: o_c_rdata valid.
- o_c_rdata  out  DATA_W  CPU read data.
- i_l_req, i_l_we, i_l_addr, i_l_wdata  in  1/1/ADDR_W/DATA_W  loader request fields, same rules as the CPU port.
- o_l_gnt, o_l_rvalid, o_l_rdata  out  1/1/DATA_W  loader responses, same rules as the CPU port.
- i_l_lock  in  1  while 1, CPU requests are never selected.
- o_mem_en  out  1  RAM enable.
- o_mem_we  out  1  RAM write enable.
- o_mem_addr  out  ADDR_W  RAM address.
- o_mem_wdata  out  DATA_W  RAM write data.
- i_mem_rdata  in  DATA_W  RAM read data; valid the cycle after an enabled read.

Behaviour:
- Reset (async, active-low):
  - State=IDLE.
  - All outputs 0: gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata, rdata.
  - Winner latch cleared; last_winner=LDR, so the CPU wins the first tie.
- State machine (registered state; IDLE, ACCESS, WAIT):
  - IDLE: evaluate eligible requests. CPU is eligible only if i_c_req & ~i_l_lock; loader is eligible if i_l_req.
    - One eligible: select it.
    - Both eligible: select the requester that is not last_winner.
    - On selection: latch we/addr/wdata/owner, update last_winner, go to ACCESS.
    - None eligible: stay in IDLE.
  - ACCESS (exactly 1 cycle):
    - o_mem_en=1; o_mem_we/addr/wdata come from the latch; owner's gnt=1.
    - Write: go to IDLE; RAM is written at the end of this cycle.
    - Read: go to WAIT.
  - WAIT (1 cycle): mem_en=0; capture i_mem_rdata into the owner's rdata register; go to IDLE.
  - Owner's rvalid is a registered pulse in the cycle after WAIT.
  - mem_* outputs are registered/derived from the latch; never combinational from i_*_req.
- Latency, request sampled in IDLE at cycle T:
  - gnt at T+1.
  - Write completes at the end of T+1.
  - Read: rvalid and rdata at T+3.
  - Back-to-back throughput: 1 write per 2 cycles, 1 read per 3 cycles.
- Response data:
  - o_*_rdata holds its last value until the next read by that port.
  - The other port's rdata is untouched.
- Handshake rules:
  - Requester holds req and fields stable until gnt.
  - Requester may deassert req in the gnt cycle or re-request immediately.
  - Fields are sampled only in IDLE; changes after selection do not affect the access in flight.
  - Req dropped after selection (protocol violation): the latched access still completes, with gnt and rvalid as normal.
- Simultaneous events:
  - Both requesters continuously requesting: grants strictly alternate, CPU first after reset.
  - i_l_lock rising during a CPU access in flight: that access completes; lock applies from the next IDLE selection.
  - i_l_lock with no loader request: arbiter idles and the CPU waits.
- Reset asserted mid-ACCESS/WAIT:
  - Access aborted; mem_en drops immediately.
  - No rvalid is produced.
  - Requesters must re-request after reset.

Test Plan:
- CPU-only write then read: c_req, we=1, addr=0x10, wdata=0xA5 -> c_gnt at T+1, mem_we=1, mem_addr=0x10. Then read 0x10 -> c_rvalid at T+3 with c_rdata=0xA5; l_* outputs stay 0.
- Contention: both ports request reads continuously, CPU addr 0x01 and loader addr 0x02, RAM preloaded 0x11/0x22 -> gnt order C, L, C, L; c_rdata=0x11, l_rdata=0x22; no cycle has both gnts.
- Lock: i_l_lock=1 with c_req held and the loader writing 0x33 to 0x05, 0x44 to 0x06 -> no c_gnt while locked. Release lock -> c_gnt within 1 cycle of returning to IDLE; a CPU read of 0x06 returns 0x44.
- Field change after selection: CPU read of 0x20 selected, then i_c_addr changes to 0x30 during ACCESS -> mem_addr=0x20; rdata is the RAM content at 0x20.
- Reset mid-read: assert i_rstn=0 during WAIT -> all outputs 0 immediately, no rvalid after release. First tie after reset is granted to the CPU.
- Idle: no requests for 20 cycles -> mem_en=0 throughout; state remains IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the CPU
// and the loader/debug port; one access in flight, loader lock holds off the CPU.
module mem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_c_req,
   input  logic              i_c_we,
   input  logic [ADDR_W-1:0] i_c_addr,
   input  logic [DATA_W-1:0] i_c_wdata,
   output logic              o_c_gnt,
   output logic              o_c_rvalid,
   output logic [DATA_W-1:0] o_c_rdata,
   input  logic              i_l_req,
   input  logic              i_l_we,
   input  logic [ADDR_W-1:0] i_l_addr,
   input  logic [DATA_W-1:0] i_l_wdata,
   output logic              o_l_gnt,
   output logic              o_l_rvalid,
   output logic [DATA_W-1:0] o_l_rdata,
   input  logic              i_l_lock,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_LDR = 1'b1;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                c_gnt_q, c_gnt_d;
   logic                l_gnt_q, l_gnt_d;
   logic                c_rvalid_q, c_rvalid_d;
   logic                l_rvalid_q, l_rvalid_d;
   logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
   logic [DATA_W-1:0]   l_rdata_q, l_rdata_d;
   logic                c_elig_s;
   logic                l_elig_s;
   logic                pick_ldr_s;

   // Next-state, selection and response logic
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      c_gnt_d     = 1'b0;
      l_gnt_d     = 1'b0;
      c_rvalid_d  = 1'b0;
      l_rvalid_d  = 1'b0;
      c_rdata_d   = c_rdata_q;
      l_rdata_d   = l_rdata_q;
      c_elig_s    = i_c_req & ~i_l_lock;
      l_elig_s    = i_l_req;
      // On a tie the loader wins only when the CPU was served last
      pick_ldr_s  = l_elig_s & (~c_elig_s | (last_q == OWN_CPU));

      case (state_q)
         ST_IDLE: begin
            if (c_elig_s | l_elig_s) begin
               owner_d  = pick_ldr_s ? OWN_LDR : OWN_CPU;
               last_d   = pick_ldr_s ? OWN_LDR : OWN_CPU;
               mem_en_d = 1'b1;
               if (pick_ldr_s) begin
                  mem_we_d    = i_l_we;
                  mem_addr_d  = i_l_addr;
                  mem_wdata_d = i_l_wdata;
                  l_gnt_d     = 1'b1;
               end else begin
                  mem_we_d    = i_c_we;
                  mem_addr_d  = i_c_addr;
                  mem_wdata_d = i_c_wdata;
                  c_gnt_d     = 1'b1;
               end
               state_d = ST_ACCESS;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (mem_we_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (owner_q == OWN_LDR) begin
               l_rdata_d  = i_mem_rdata;
               l_rvalid_d = 1'b1;
            end else begin
               c_rdata_d  = i_mem_rdata;
               c_rvalid_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, access latch and registered outputs
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_CPU;
         last_q      <= OWN_LDR;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
         c_gnt_q     <= 1'b0;
         l_gnt_q     <= 1'b0;
         c_rvalid_q  <= 1'b0;
         l_rvalid_q  <= 1'b0;
         c_rdata_q   <= {DATA_W{1'b0}};
         l_rdata_q   <= {DATA_W{1'b0}};
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         c_gnt_q     <= c_gnt_d;
         l_gnt_q     <= l_gnt_d;
         c_rvalid_q  <= c_rvalid_d;
         l_rvalid_q  <= l_rvalid_d;
         c_rdata_q   <= c_rdata_d;
         l_rdata_q   <= l_rdata_d;
      end
   end

   assign o_c_gnt     = c_gnt_q;
   assign o_l_gnt     = l_gnt_q;
   assign o_c_rvalid  = c_rvalid_q;
   assign o_l_rvalid  = l_rvalid_q;
   assign o_c_rdata   = c_rdata_q;
   assign o_l_rdata   = l_rdata_q;
   assign o_mem_en    = mem_en_q;
   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration rules and RAM contents.
module tb_mem_arbiter;

   logic       clk = 1'b0;
   logic       rstn;
   logic       c_req, c_we, l_req, l_we, l_lock;
   logic [7:0] c_addr, c_wdata, l_addr, l_wdata;
   logic       c_gnt, c_rvalid, l_gnt, l_rvalid;
   logic [7:0] c_rdata, l_rdata;
   logic       mem_en, mem_we;
   logic [7:0] mem_addr, mem_wdata;
   logic [7:0] mem_rdata = 8'h00;
   logic [7:0] ram [0:255];
   logic       pl_en = 1'b0;
   logic [7:0] pl_addr = 8'h00, pl_data = 8'h00;
   int         n_checks = 0;
   int         n_fail = 0;

   mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .i_clk(clk), .i_rstn(rstn),
      .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
      .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
      .i_l_req(l_req), .i_l_we(l_we), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
      .o_l_gnt(l_gnt), .o_l_rvalid(l_rvalid), .o_l_rdata(l_rdata),
      .i_l_lock(l_lock),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM, with a back door for preloading while idle
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end else if (pl_en) begin
         ram[pl_addr] <= pl_data;
      end
   end

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      c_req = 1'b0; l_req = 1'b0; l_lock = 1'b0;
      c_we = 1'b0; l_we = 1'b0;
      c_addr = 8'h00; l_addr = 8'h00; c_wdata = 8'h00; l_wdata = 8'h00;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      logic [37:0] outs;
      do_reset();
      @(negedge clk);
      rstn = 1'b0;
      #1;
      outs = {c_gnt, c_rvalid, c_rdata, l_gnt, l_rvalid, l_rdata, mem_en, mem_we, mem_addr, mem_wdata};
      n_checks++; if (outs !== 38'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      outs = {c_gnt, c_rvalid, c_rdata, l_gnt, l_rvalid, l_rdata, mem_en, mem_we, mem_addr, mem_wdata};
      n_checks++; if (outs !== 38'h0) begin n_fail++; $display("FAIL reset_idle_outputs: got %h expected 0", outs); end
   endtask

   task automatic test_cpu_write_read();
      do_reset();
      c_req = 1'b1; c_we = 1'b1; c_addr = 8'h10; c_wdata = 8'hA5;
      @(negedge clk);
      n_checks++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b expected 1", c_gnt); end
      n_checks++; if ({mem_en, mem_we} !== 2'b11) begin n_fail++; $display("FAIL wr_en_we: got %b expected 11", {mem_en, mem_we}); end
      n_checks++; if ({mem_addr, mem_wdata} !== 16'h10A5) begin n_fail++; $display("FAIL wr_addr_data: got %h expected 10a5", {mem_addr, mem_wdata}); end
      c_req = 1'b0;
      @(negedge clk);
      n_checks++; if ({mem_en, c_gnt, l_gnt} !== 3'b000) begin n_fail++; $display("FAIL wr_done_idle: got %b expected 000", {mem_en, c_gnt, l_gnt}); end
      c_req = 1'b1; c_we = 1'b0;
      @(negedge clk);
      n_checks++; if ({c_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 8'h10}) begin n_fail++; $display("FAIL rd_gnt: got %h expected %h", {c_gnt, mem_en, mem_we, mem_addr}, {3'b110, 8'h10}); end
      c_req = 1'b0;
      @(negedge clk);
      n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_early_rvalid: got %b expected 0", c_rvalid); end
      @(negedge clk);
      n_checks++; if ({c_rvalid, c_rdata} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL rd_data: got %h expected %h", {c_rvalid, c_rdata}, {1'b1, 8'hA5}); end
      n_checks++; if ({l_gnt, l_rvalid, l_rdata} !== 10'h0) begin n_fail++; $display("FAIL rd_ldr_quiet: got %h expected 0", {l_gnt, l_rvalid, l_rdata}); end
      @(negedge clk);
      n_checks++; if ({c_rvalid, c_rdata} !== {1'b0, 8'hA5}) begin n_fail++; $display("FAIL rd_hold: got %h expected %h", {c_rvalid, c_rdata}, {1'b0, 8'hA5}); end
   endtask

   task automatic test_contention();
      int order [0:3];
      int g = 0;
      do_reset();
      preload(8'h01, 8'h11);
      preload(8'h02, 8'h22);
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h01;
      l_req = 1'b1; l_we = 1'b0; l_addr = 8'h02;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         n_checks++; if (c_gnt === 1'b1 && l_gnt === 1'b1) begin n_fail++; $display("FAIL cont_both_gnt: got 11 expected at most one"); end
         if (c_gnt === 1'b1 && g < 4) begin order[g] = 0; g++; end
         if (l_gnt === 1'b1 && g < 4) begin order[g] = 1; g++; end
      end
      c_req = 1'b0; l_req = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++; if (g !== 4) begin n_fail++; $display("FAIL cont_gnt_count: got %0d expected 4", g); end
      for (int i = 0; i < 4; i++) begin
         if (i < g) begin
            n_checks++; if (order[i] !== i % 2) begin n_fail++; $display("FAIL cont_order[%0d]: got %0d expected %0d", i, order[i], i % 2); end
         end
      end
      n_checks++; if ({c_rdata, l_rdata} !== 16'h1122) begin n_fail++; $display("FAIL cont_rdata: got %h expected 1122", {c_rdata, l_rdata}); end
   endtask

   task automatic test_lock();
      int phase = 0;
      do_reset();
      l_lock = 1'b1;
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h06;
      l_req = 1'b1; l_we = 1'b1; l_addr = 8'h05; l_wdata = 8'h33;
      for (int i = 0; i < 8 && phase < 2; i++) begin
         @(negedge clk);
         n_checks++; if (c_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_cpu_gnt: got %b expected 0", c_gnt); end
         if (l_gnt === 1'b1) begin
            if (phase == 0) begin l_addr = 8'h06; l_wdata = 8'h44; end
            else            l_req = 1'b0;
            phase++;
         end
      end
      n_checks++; if (phase !== 2) begin n_fail++; $display("FAIL lock_ldr_gnts: got %0d expected 2", phase); end
      l_req = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_checks++; if (c_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_hold_cpu: got %b expected 0", c_gnt); end
      end
      l_lock = 1'b0;
      @(negedge clk);
      n_checks++; if ({c_gnt, mem_addr} !== {1'b1, 8'h06}) begin n_fail++; $display("FAIL unlock_gnt: got %h expected %h", {c_gnt, mem_addr}, {1'b1, 8'h06}); end
      c_req = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if ({c_rvalid, c_rdata} !== {1'b1, 8'h44}) begin n_fail++; $display("FAIL unlock_rdata: got %h expected %h", {c_rvalid, c_rdata}, {1'b1, 8'h44}); end
   endtask

   task automatic test_field_change();
      do_reset();
      preload(8'h20, 8'h5A);
      preload(8'h30, 8'hC3);
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h20;
      @(negedge clk);
      n_checks++; if ({c_gnt, mem_addr} !== {1'b1, 8'h20}) begin n_fail++; $display("FAIL fc_gnt: got %h expected %h", {c_gnt, mem_addr}, {1'b1, 8'h20}); end
      c_addr = 8'h30; c_req = 1'b0;
      #1;
      n_checks++; if (mem_addr !== 8'h20) begin n_fail++; $display("FAIL fc_addr_stable: got %h expected 20", mem_addr); end
      repeat (2) @(negedge clk);
      n_checks++; if ({c_rvalid, c_rdata} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL fc_rdata: got %h expected %h", {c_rvalid, c_rdata}, {1'b1, 8'h5A}); end
   endtask

   task automatic test_reset_mid_read();
      logic [37:0] outs;
      do_reset();
      preload(8'h20, 8'h5A);
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h20;
      @(negedge clk);
      c_req = 1'b0; rstn = 1'b0;
      #1;
      n_checks++; if ({mem_en, c_gnt} !== 2'b00) begin n_fail++; $display("FAIL rst_access_drop: got %b expected 00", {mem_en, c_gnt}); end
      @(negedge clk);
      rstn = 1'b1;
      repeat (4) begin
         @(negedge clk);
         n_checks++; if ({c_rvalid, c_rdata} !== 9'h0) begin n_fail++; $display("FAIL rst_access_rvalid: got %h expected 0", {c_rvalid, c_rdata}); end
      end
      c_req = 1'b1;
      @(negedge clk);
      c_req = 1'b0;
      @(negedge clk);
      rstn = 1'b0;
      #1;
      outs = {c_gnt, c_rvalid, c_rdata, l_gnt, l_rvalid, l_rdata, mem_en, mem_we, mem_addr, mem_wdata};
      n_checks++; if (outs !== 38'h0) begin n_fail++; $display("FAIL rst_wait_outputs: got %h expected 0", outs); end
      @(negedge clk);
      rstn = 1'b1;
      repeat (4) begin
         @(negedge clk);
         n_checks++; if ({c_rvalid, l_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_wait_rvalid: got %b expected 00", {c_rvalid, l_rvalid}); end
      end
      c_req = 1'b1; l_req = 1'b1; l_we = 1'b0; l_addr = 8'h21;
      @(negedge clk);
      n_checks++; if ({c_gnt, l_gnt} !== 2'b10) begin n_fail++; $display("FAIL rst_first_tie: got %b expected 10", {c_gnt, l_gnt}); end
      c_req = 1'b0; l_req = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_idle();
      do_reset();
      repeat (20) begin
         @(negedge clk);
         n_checks++; if ({mem_en, c_gnt, l_gnt} !== 3'b000) begin n_fail++; $display("FAIL idle_quiet: got %b expected 000", {mem_en, c_gnt, l_gnt}); end
      end
      l_req = 1'b1; l_we = 1'b1; l_addr = 8'h40; l_wdata = 8'h01;
      @(negedge clk);
      n_checks++; if ({l_gnt, mem_en} !== 2'b11) begin n_fail++; $display("FAIL idle_then_gnt: got %b expected 11", {l_gnt, mem_en}); end
      l_req = 1'b0;
      @(negedge clk);
   endtask

   // Randomized traffic checked against a transaction-level model
   task automatic test_random();
      logic [7:0] shadow [0:15];
      int         idle_from, c_rv_at, l_rv_at;
      bit         prev_idle, pc_elig, pl_elig, last_l, exp_c, exp_l, pick_l;
      logic       sel_we;
      logic [7:0] sel_addr, sel_wdata, c_pend, l_pend, c_rd_m, l_rd_m;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         shadow[i] = 8'($urandom);
         preload(8'(i), shadow[i]);
      end
      idle_from = 0; prev_idle = 1'b1; pc_elig = 1'b0; pl_elig = 1'b0; last_l = 1'b1;
      c_rv_at = -1; l_rv_at = -1; c_rd_m = 8'h00; l_rd_m = 8'h00; c_pend = 8'h00; l_pend = 8'h00;
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         exp_c = 1'b0; exp_l = 1'b0; pick_l = 1'b0;
         if (prev_idle && (pc_elig || pl_elig)) begin
            pick_l = (pc_elig && pl_elig) ? !last_l : pl_elig;
            exp_c = !pick_l; exp_l = pick_l;
         end
         n_checks++; if ({c_gnt, l_gnt, mem_en} !== {exp_c, exp_l, exp_c | exp_l}) begin n_fail++; $display("FAIL rnd_gnt cyc %0d: got %b expected %b", n, {c_gnt, l_gnt, mem_en}, {exp_c, exp_l, exp_c | exp_l}); end
         if (exp_c || exp_l) begin
            sel_we = pick_l ? l_we : c_we;
            sel_addr = pick_l ? l_addr : c_addr;
            sel_wdata = pick_l ? l_wdata : c_wdata;
            n_checks++; if ({mem_we, mem_addr} !== {sel_we, sel_addr}) begin n_fail++; $display("FAIL rnd_access cyc %0d: got %h expected %h", n, {mem_we, mem_addr}, {sel_we, sel_addr}); end
            if (sel_we) begin
               n_checks++; if (mem_wdata !== sel_wdata) begin n_fail++; $display("FAIL rnd_wdata cyc %0d: got %h expected %h", n, mem_wdata, sel_wdata); end
               shadow[sel_addr[3:0]] = sel_wdata;
               idle_from = n + 1;
            end else begin
               if (pick_l) begin l_pend = shadow[sel_addr[3:0]]; l_rv_at = n + 2; end
               else        begin c_pend = shadow[sel_addr[3:0]]; c_rv_at = n + 2; end
               idle_from = n + 2;
            end
            last_l = pick_l;
         end
         if (c_rv_at == n) c_rd_m = c_pend;
         if (l_rv_at == n) l_rd_m = l_pend;
         n_checks++; if ({c_rvalid, c_rdata} !== {c_rv_at == n, c_rd_m}) begin n_fail++; $display("FAIL rnd_c_resp cyc %0d: got %h expected %h", n, {c_rvalid, c_rdata}, {c_rv_at == n, c_rd_m}); end
         n_checks++; if ({l_rvalid, l_rdata} !== {l_rv_at == n, l_rd_m}) begin n_fail++; $display("FAIL rnd_l_resp cyc %0d: got %h expected %h", n, {l_rvalid, l_rdata}, {l_rv_at == n, l_rd_m}); end
         if ((exp_c && $urandom_range(1, 0) == 1) || (!exp_c && !c_req && $urandom_range(3, 0) == 0)) begin
            c_req = 1'b1; c_we = 1'($urandom_range(1, 0));
            c_addr = {4'h0, 4'($urandom_range(15, 0))}; c_wdata = 8'($urandom);
         end else if (exp_c) begin
            c_req = 1'b0;
         end
         if ((exp_l && $urandom_range(1, 0) == 1) || (!exp_l && !l_req && $urandom_range(3, 0) == 0)) begin
            l_req = 1'b1; l_we = 1'($urandom_range(1, 0));
            l_addr = {4'h0, 4'($urandom_range(15, 0))}; l_wdata = 8'($urandom);
         end else if (exp_l) begin
            l_req = 1'b0;
         end
         if ($urandom_range(19, 0) == 0) l_lock = !l_lock;
         pc_elig = c_req && !l_lock;
         pl_elig = l_req;
         prev_idle = (n >= idle_from);
      end
      c_req = 1'b0; l_req = 1'b0; l_lock = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      rstn = 1'b0;
      c_req = 1'b0; c_we = 1'b0; c_addr = 8'h00; c_wdata = 8'h00;
      l_req = 1'b0; l_we = 1'b0; l_addr = 8'h00; l_wdata = 8'h00; l_lock = 1'b0;
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      test_reset();
      test_cpu_write_read();
      test_contention();
      test_lock();
      test_field_change();
      test_reset_mid_read();
      test_idle();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
